// File: rtl/dma_ctrl_pkg.sv
// Shared types and constants for the burst DMA controller.
package dma_ctrl_pkg;

    localparam int MAX_BEATS  = 16;
    localparam int PAGE_BYTES = 4096;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CALC,
        S_RD_REQ,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_DATA,
        S_WR_RESP,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/dma_beat_fifo.sv
// Synchronous beat buffer between the read and write phases of a burst.
// The head word is presented combinationally on o_rdata.
module dma_beat_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

endmodule

// File: rtl/dma_burst_ctrl.sv
// Word-copy DMA: splits a job into bursts that never cross a 4 KB page,
// reads each burst into the beat buffer, then writes it out in order.
module dma_burst_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BEATS  = dma_ctrl_pkg::MAX_BEATS
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [31:0] len_words,
    output logic        busy,
    output logic        done,
    output logic [3:0]  burst_len,
    output logic        AR_valid,
    output logic [31:0] read_addr,
    input  logic        read_data_valid,
    input  logic [31:0] read_data,
    output logic        AW_valid,
    output logic [31:0] write_addr,
    output logic        W_valid,
    output logic [31:0] write_data,
    output logic        W_last,
    input  logic        master_W_done,
    input  logic        master_B_done,
    output logic [3:0]  o_dbg_state
);
    import dma_ctrl_pkg::*;

    localparam int CW  = $clog2(MAX_BEATS + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    state_t         r_state;
    state_t         w_next_state;
    logic [31:0]    r_src;
    logic [31:0]    r_dst;
    logic [31:0]    r_remaining;
    logic [CW-1:0]  r_beats;
    logic [CW-1:0]  r_rd_cnt;
    logic [CW-1:0]  r_wr_cnt;
    logic [3:0]     r_burst_len;
    logic [CW-1:0]  w_beats;
    logic [31:0]    w_src_room;
    logic [31:0]    w_dst_room;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [FCW-1:0] w_count;
    logic           w_rd_last;
    logic           w_wr_last;

    // AR_valid/AW_valid are one-cycle strobes with no ready; a write beat
    // transfers on any cycle where W_valid and master_W_done are both high,
    // and W_valid never drops while the buffer still holds data.
    assign w_push    = (r_state == S_RD_DATA) && read_data_valid && !w_full;
    assign w_pop     = (r_state == S_WR_DATA) && master_W_done && !w_empty;
    assign w_rd_last = (r_rd_cnt == r_beats - CW'(1));
    assign w_wr_last = (r_wr_cnt == r_beats - CW'(1));

    // Burst size: the smallest of words left, the burst cap and the words
    // remaining before either address reaches its next 4 KB page.
    always_comb begin
        w_src_room = (32'(PAGE_BYTES) - {20'd0, r_src[11:0]}) >> 2;
        w_dst_room = (32'(PAGE_BYTES) - {20'd0, r_dst[11:0]}) >> 2;
        w_beats    = (r_remaining > 32'(MAX_BEATS)) ? CW'(MAX_BEATS) : r_remaining[CW-1:0];
        if (w_src_room < 32'(w_beats)) begin
            w_beats = w_src_room[CW-1:0];
        end
        if (w_dst_room < 32'(w_beats)) begin
            w_beats = w_dst_room[CW-1:0];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_CALC;
            S_CALC:    w_next_state = (r_remaining == '0) ? S_DONE : S_RD_REQ;
            S_RD_REQ:  w_next_state = S_RD_DATA;
            S_RD_DATA: if (w_push && w_rd_last) w_next_state = S_WR_REQ;
            S_WR_REQ:  w_next_state = S_WR_DATA;
            S_WR_DATA: if (w_pop && w_wr_last) w_next_state = S_WR_RESP;
            S_WR_RESP: if (master_B_done) w_next_state = S_NEXT;
            S_NEXT:    w_next_state = S_CALC;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        AR_valid = (r_state == S_RD_REQ);
        AW_valid = (r_state == S_WR_REQ);
        W_valid  = (r_state == S_WR_DATA) && (w_count != '0);
        W_last   = W_valid && w_wr_last;
    end

    assign read_addr   = r_src;
    assign write_addr  = r_dst;
    assign burst_len   = r_burst_len;
    assign o_dbg_state = r_state;

    // Addresses and length only move in IDLE, CALC and NEXT, so they hold
    // steady for the whole read/write/response span of a burst.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_beats     <= '0;
            r_burst_len <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src       <= src_addr & ~32'h3;
                        r_dst       <= dst_addr & ~32'h3;
                        r_remaining <= len_words;
                    end
                end
                S_CALC: begin
                    r_rd_cnt <= '0;
                    r_wr_cnt <= '0;
                    if (r_remaining != '0) begin
                        r_beats     <= w_beats;
                        r_burst_len <= 4'(w_beats - CW'(1));
                    end
                end
                S_RD_DATA: begin
                    if (w_push) r_rd_cnt <= r_rd_cnt + CW'(1);
                end
                S_WR_DATA: begin
                    if (w_pop) r_wr_cnt <= r_wr_cnt + CW'(1);
                end
                S_NEXT: begin
                    r_src       <= r_src + 32'({r_beats, 2'b00});
                    r_dst       <= r_dst + 32'({r_beats, 2'b00});
                    r_remaining <= r_remaining - 32'(r_beats);
                end
                default: ;
            endcase
        end
    end

    dma_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_beat_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (read_data),
        .o_rdata (write_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
